// File: rtl/mult_err_pkg.sv
// Shared types and constants for the approximate-multiplier error statistics collector.
package mult_err_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } err_state_t;

    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;
    localparam int ED_W      = 16;
    localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/mult_err_ed.sv
// Exact 8x8 product and its absolute distance from the approximate product.
module mult_err_ed
    import mult_err_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [PROD_W-1:0] r_approx,
    output logic [ED_W-1:0]   ed
);

    logic [PROD_W-1:0] exact;

    // The exact product never exceeds 65025, so both differences fit in ED_W bits.
    always_comb begin
        exact = PROD_W'(a) * PROD_W'(b);
        if (exact >= r_approx) begin
            ed = ED_W'(exact - r_approx);
        end else begin
            ed = ED_W'(r_approx - exact);
        end
    end

endmodule

// File: rtl/mult_err_stats.sv
// Streaming error-distance statistics over a fixed-length run of multiplier samples:
// capture stage, exact/ED stage, then accumulation of sum, maximum and error count.
module mult_err_stats
    import mult_err_pkg::*;
#(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      a,
    input  logic [OP_W-1:0]      b,
    input  logic [PROD_W-1:0]    r_approx,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [ED_W-1:0]      max_ed,
    output logic [15:0]          err_cnt
);

    err_state_t          state, state_nx;
    logic [15:0]         acc_cnt;
    logic [1:0]          drain_cnt;
    logic                accept;
    logic                clear;

    logic                s1_valid;
    logic [OP_W-1:0]     s1_a, s1_b;
    logic [PROD_W-1:0]   s1_r;
    logic                s2_valid;
    logic [ED_W-1:0]     s2_ed;
    logic [ED_W-1:0]     ed_comb;
    logic [ACC_W:0]      sum_wide;

    assign accept = in_valid && in_ready;
    assign clear  = (state == IDLE) && start;

    // Next-state and status outputs; start is only honoured from IDLE.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (acc_cnt < 16'(N_SAMPLES));
                if (accept && (acc_cnt == 16'(N_SAMPLES - 1))) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'(DRAIN_CYC - 1)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            if (clear) begin
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    mult_err_ed u_ed (
        .a        (s1_a),
        .b        (s1_b),
        .r_approx (s1_r),
        .ed       (ed_comb)
    );

    // Valid bits travel with the data so bubbles never touch the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_r     <= '0;
            s2_valid <= 1'b0;
            s2_ed    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= a;
                s1_b <= b;
                s1_r <= r_approx;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed_comb;
            end
        end
    end

    assign sum_wide = {1'b0, sum_ed} + (ACC_W + 1)'(s2_ed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (s2_valid) begin
            sum_ed <= sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            if (s2_ed > max_ed) max_ed <= s2_ed;
            if (s2_ed != '0) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mult_err_stats.sv
// Directed self-checking bench for mult_err_stats with hand-computed statistics and timing.
module tb_mult_err_stats;

    localparam int N  = 4;
    localparam int AW = 17;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    a        = '0;
    logic [7:0]    b        = '0;
    logic [15:0]   r_approx = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] sum_ed;
    logic [15:0]   max_ed;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int startCyc = 0;

    logic [7:0]  va [16];
    logic [7:0]  vb [16];
    logic [15:0] vr [16];
    logic        vv [16];
    logic        vs [16];
    logic        readyLog [16];

    mult_err_stats #(
        .N_SAMPLES (N),
        .ACC_W     (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .r_approx (r_approx),
        .busy     (busy),
        .done     (done),
        .sum_ed   (sum_ed),
        .max_ed   (max_ed),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setVec(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] r, input logic v);
        va[i] = x;
        vb[i] = y;
        vr[i] = r;
        vv[i] = v;
        vs[i] = 1'b0;
    endtask

    task automatic checkStats(input string tag, input int s, input int m, input int c);
        checkOutput({tag, "_sum"}, 32'(sum_ed), s);
        checkOutput({tag, "_max"}, 32'(max_ed), m);
        checkOutput({tag, "_cnt"}, 32'(err_cnt), c);
    endtask

    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic doStart(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        startCyc = cyc;
        checkOutput({tag, "_busy_run"}, 32'(busy), 1);
        checkOutput({tag, "_ready_run"}, 32'(in_ready), 1);
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            a           = va[i];
            b           = vb[i];
            r_approx    = vr[i];
            in_valid    = vv[i];
            start       = vs[i];
            readyLog[i] = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finishRun(input string tag, input int expEdge, input logic pulseInDrain,
                             input int s, input int m, input int c);
        int seen;
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = cyc - startCyc;
                break;
            end
            start = pulseInDrain && busy && !in_ready;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checkOutput({tag, "_done_edge"}, seen, expEdge);
        if (seen >= 0) begin
            checkOutput({tag, "_busy_done"}, 32'(busy), 0);
            checkStats(tag, s, m, c);
            @(posedge clk);
            #1;
            checkOutput({tag, "_done_pulse"}, 32'(done), 0);
            repeat (2) @(posedge clk);
            #1;
            checkStats({tag, "_hold"}, s, m, c);
        end
    endtask

    initial begin
        int doneSeen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkStats("rst", 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_ready", 32'(in_ready), 0);

        // Exact products: no error
        setVec(0, 8'd3, 8'd5, 16'd15, 1'b1);
        setVec(1, 8'd255, 8'd255, 16'd65025, 1'b1);
        setVec(2, 8'd0, 8'd7, 16'd0, 1'b1);
        setVec(3, 8'd10, 8'd10, 16'd100, 1'b1);
        doStart("exact");
        applyStimulus(4);
        finishRun("exact", N + 2, 1'b0, 0, 0, 0);

        // Known errors: ED 4, 10, 0, 0
        setVec(0, 8'd12, 8'd12, 16'd140, 1'b1);
        setVec(1, 8'd200, 8'd3, 16'd610, 1'b1);
        setVec(2, 8'd1, 8'd1, 16'd1, 1'b1);
        setVec(3, 8'd2, 8'd2, 16'd4, 1'b1);
        doStart("known");
        applyStimulus(4);
        finishRun("known", N + 2, 1'b0, 14, 10, 2);

        // Bubbles carry junk; extras after the 4th accept must be ignored
        setVec(0, 8'd3, 8'd3, 16'd10, 1'b1);
        setVec(1, 8'd255, 8'd255, 16'd0, 1'b0);
        setVec(2, 8'd4, 8'd4, 16'd16, 1'b1);
        setVec(3, 8'd255, 8'd255, 16'd0, 1'b0);
        setVec(4, 8'd5, 8'd5, 16'd20, 1'b1);
        setVec(5, 8'd255, 8'd255, 16'd0, 1'b0);
        setVec(6, 8'd6, 8'd6, 16'd40, 1'b1);
        setVec(7, 8'd0, 8'd0, 16'd65535, 1'b1);
        setVec(8, 8'd0, 8'd0, 16'd65535, 1'b1);
        doStart("bubble");
        applyStimulus(9);
        checkOutput("bubble_ready_gap", 32'(readyLog[1]), 1);
        checkOutput("bubble_ready_after", 32'(readyLog[7]), 0);
        checkOutput("bubble_ready_extra", 32'(readyLog[8]), 0);
        finishRun("bubble", 9, 1'b0, 10, 5, 3);

        // Saturation of the 17-bit sum
        for (int i = 0; i < 4; i++) setVec(i, 8'd0, 8'd0, 16'd65535, 1'b1);
        doStart("sat");
        applyStimulus(4);
        finishRun("sat", N + 2, 1'b0, 131071, 65535, 4);

        // Reset in the middle of a run
        setVec(0, 8'd0, 8'd0, 16'd65535, 1'b1);
        setVec(1, 8'd0, 8'd0, 16'd65535, 1'b1);
        doStart("midrst");
        applyStimulus(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_ready", 32'(in_ready), 0);
        checkStats("midrst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("midrst_no_done", doneSeen, 0);
        checkStats("midrst_after", 0, 0, 0);

        // Clean run after reset: ED 6, 0, 0, 1
        setVec(0, 8'd7, 8'd8, 16'd50, 1'b1);
        setVec(1, 8'd9, 8'd9, 16'd81, 1'b1);
        setVec(2, 8'd2, 8'd3, 16'd6, 1'b1);
        setVec(3, 8'd100, 8'd100, 16'd9999, 1'b1);
        doStart("clean");
        applyStimulus(4);
        finishRun("clean", N + 2, 1'b0, 7, 6, 2);

        // start pulses during RUN and DRAIN have no effect: ED 1, 0, 4, 0
        setVec(0, 8'd2, 8'd2, 16'd5, 1'b1);
        setVec(1, 8'd3, 8'd3, 16'd9, 1'b1);
        setVec(2, 8'd4, 8'd4, 16'd20, 1'b1);
        setVec(3, 8'd5, 8'd5, 16'd25, 1'b1);
        vs[1] = 1'b1;
        vs[2] = 1'b1;
        doStart("igstart");
        applyStimulus(4);
        finishRun("igstart", N + 2, 1'b1, 5, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
